// File: rtl/lut4_sweep_checker_if.sv
// lut4_sweep_checker_if: control, LUT stimulus/response and result bundle for the sweep checker
interface lut4_sweep_checker_if;
    logic       start;
    logic [3:0] lut_i;
    logic       lut_o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic       fail_valid;

    modport master (
        input  start, lut_o,
        output lut_i, busy, done, pass, err_count, first_fail, fail_valid
    );

    modport slave (
        output start, lut_o,
        input  lut_i, busy, done, pass, err_count, first_fail, fail_valid
    );
endinterface

// File: rtl/lut4_sweep_checker.sv
// lut4_sweep_checker: sweeps a LUT4 through all 16 codes and checks its output against a truth table
module lut4_sweep_checker #(
    parameter logic [15:0] EXPECTED      = 16'h0E13,
    parameter int          SETTLE_CYCLES = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    lut4_sweep_checker_if.master bus
);
    generate
        if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("SETTLE_CYCLES must be within 3..255");
        end
    endgenerate

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t     state, state_n;
    logic       s1, s2;
    logic [7:0] cnt, cnt_n;
    logic [3:0] lut_i, lut_i_n;
    logic       busy, busy_n;
    logic       done, done_n;
    logic       pass, pass_n;
    logic [4:0] err, err_n;
    logic [3:0] ff, ff_n;
    logic       fv, fv_n;
    logic       mismatch;

    assign mismatch = s2 != EXPECTED[lut_i];

    // two-flop synchronizer for the asynchronous LUT output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.lut_o;
            s2 <= s1;
        end
    end

    // state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            lut_i <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            err   <= 5'd0;
            ff    <= 4'd0;
            fv    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lut_i <= lut_i_n;
            busy  <= busy_n;
            done  <= done_n;
            pass  <= pass_n;
            err   <= err_n;
            ff    <= ff_n;
            fv    <= fv_n;
        end
    end

    // sweep sequencing: start clears results, each code is sampled when its settle count expires
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lut_i_n = lut_i;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err;
        ff_n    = ff;
        fv_n    = fv;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = SETTLE;
                    cnt_n   = RELOAD;
                    lut_i_n = 4'd0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = 5'd0;
                    ff_n    = 4'd0;
                    fv_n    = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    if (mismatch) begin
                        err_n = err + 5'd1;
                        if (!fv) begin
                            ff_n = lut_i;
                            fv_n = 1'b1;
                        end
                    end
                    if (lut_i != 4'd15) begin
                        lut_i_n = lut_i + 4'd1;
                        cnt_n   = RELOAD;
                    end else begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = err_n == 5'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.lut_i      = lut_i;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_count  = err;
    assign bus.first_fail = ff;
    assign bus.fail_valid = fv;
endmodule
